// File: rtl/sipo.sv
// Serial-in parallel-out deserializer with sync-framed input and valid/ready output.
// Define SIPO_PARITY_EN to expect a trailing even-parity bit after the WIDTH data bits.
//
//   state   | meaning
//   --------+----------------------------------------------
//   S_IDLE  | waiting for sync; serial input ignored
//   S_SHIFT | frame in progress; one bit captured per cycle
module sipo #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sync,
   input  logic             data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             overrun,
   output logic             frame_err,
   output logic             parity_err
);

   localparam int CW = $clog2(WIDTH + 1);
`ifdef SIPO_PARITY_EN
   localparam int FRAME_BITS = WIDTH + 1;
`else
   localparam int FRAME_BITS = WIDTH;
`endif
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_BITS - 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
   logic             frame_err_q, frame_err_d;
   logic             complete;
   logic             accept;
   logic [WIDTH-1:0] word;

   // First serial bit ends up at the MSB (shift left) or at bit 0 (shift right).
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr, input logic b);
      if (MSB_FIRST)
         return {sr[WIDTH-2:0], b};
      else
         return {b, sr[WIDTH-1:1]};
   endfunction

`ifdef SIPO_PARITY_EN
   logic parity_err_q, parity_err_d;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sr_d        = sr_q;
      data_d      = data_q;
      valid_d     = valid_q;
      overrun_d   = overrun_q;
      frame_err_d = frame_err_q;
      complete    = 1'b0;
      word        = sr_q;
      accept      = valid_q & out_ready;

      case (state_q)
         S_IDLE: begin
            if (sync) begin
               sr_d    = shift_in('0, data_in);
               cnt_d   = CW'(1);
               state_d = S_SHIFT;
            end
         end
         default: begin
            if (sync) begin
               frame_err_d = 1'b1;
               sr_d        = shift_in('0, data_in);
               cnt_d       = CW'(1);
            end else if (cnt_q == LAST_IDX) begin
               complete = 1'b1;
               state_d  = S_IDLE;
               cnt_d    = '0;
`ifndef SIPO_PARITY_EN
               sr_d = shift_in(sr_q, data_in);
               word = sr_d;
`endif
            end else begin
               sr_d  = shift_in(sr_q, data_in);
               cnt_d = cnt_q + CW'(1);
            end
         end
      endcase

      // A word completing while the previous one is still pending is dropped,
      // unless the consumer takes the old word in this same cycle.
      if (complete) begin
         if (!valid_q || accept) begin
            data_d  = word;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (accept) begin
         valid_d = 1'b0;
      end
   end

`ifdef SIPO_PARITY_EN
   always_comb begin
      parity_err_d = parity_err_q;
      if (complete && ((^sr_q) ^ data_in))
         parity_err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         parity_err_q <= 1'b0;
      else
         parity_err_q <= parity_err_d;
   end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         sr_q        <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sr_q        <= sr_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign data_out  = data_q;
   assign out_valid = valid_q;
   assign busy      = (state_q == S_SHIFT);
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sipo.sv
// Directed bench for sipo: an MSB-first and an LSB-first instance share one serial stream.
module tb_sipo;

   logic       clk = 1'b0;
   logic       rst;
   logic       sync;
   logic       data_in;
   logic       out_ready;
   logic [7:0] dout_m, dout_l;
   logic       valid_m, valid_l, busy_m, busy_l;
   logic       ovr_m, ovr_l, ferr_m, ferr_l, perr_m, perr_l;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sipo #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .sync(sync), .data_in(data_in),
      .data_out(dout_m), .out_valid(valid_m), .out_ready(out_ready),
      .busy(busy_m), .overrun(ovr_m), .frame_err(ferr_m), .parity_err(perr_m)
   );

   sipo #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .sync(sync), .data_in(data_in),
      .data_out(dout_l), .out_valid(valid_l), .out_ready(out_ready),
      .busy(busy_l), .overrun(ovr_l), .frame_err(ferr_l), .parity_err(perr_l)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic s, input logic d);
      sync    = s;
      data_in = d;
      @(posedge clk);
      #1;
      sync = 1'b0;
   endtask

   // Sends v MSB-first with sync on the first bit; out_ready takes rdy_last for the final bit.
   task automatic send_frame(input logic [7:0] v, input logic rdy_last, input logic bad_par);
      for (int i = 7; i >= 0; i--) begin
`ifndef SIPO_PARITY_EN
         if (i == 0) out_ready = rdy_last;
`endif
         send_bit(i == 7, v[i]);
      end
`ifdef SIPO_PARITY_EN
      out_ready = rdy_last;
      send_bit(1'b0, (^v) ^ bad_par);
`endif
   endtask

   initial begin
      rst       = 1'b1;
      sync      = 1'b0;
      data_in   = 1'b0;
      out_ready = 1'b1;
      #2;
      check("rst_dout",  dout_m,  32'h0);
      check("rst_valid", valid_m, 32'h0);
      check("rst_busy",  busy_m,  32'h0);
      check("rst_ovr",   ovr_m,   32'h0);
      check("rst_ferr",  ferr_m,  32'h0);
      check("rst_perr",  perr_m,  32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // basic frame, both bit orders
      send_frame(8'hA5, 1'b1, 1'b0);
      check("a5_dout_msb",  dout_m,  32'hA5);
      check("a5_valid",     valid_m, 32'h1);
      check("a5_dout_lsb",  dout_l,  32'hA5);
      check("a5_valid_lsb", valid_l, 32'h1);
      check("a5_busy",      busy_m,  32'h0);
      send_bit(1'b0, 1'b0);
      check("a5_valid_drop", valid_m, 32'h0);
      check("a5_hold",       dout_m,  32'hA5);

      send_frame(8'h0F, 1'b1, 1'b0);
      check("0f_dout_msb", dout_m, 32'h0F);
      check("0f_dout_lsb", dout_l, 32'hF0);
      send_bit(1'b0, 1'b0);

      // completion coinciding with acceptance
      out_ready = 1'b0;
      send_frame(8'h5A, 1'b0, 1'b0);
      check("5a_dout",  dout_m,  32'h5A);
      check("5a_valid", valid_m, 32'h1);
      send_frame(8'h96, 1'b1, 1'b0);
      check("96_dout",  dout_m,  32'h96);
      check("96_valid", valid_m, 32'h1);
      check("96_ovr",   ovr_m,   32'h0);
      send_bit(1'b0, 1'b0);
      check("96_valid_drop", valid_m, 32'h0);

      // sync mid-frame restarts
      out_ready = 1'b1;
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b1);
      send_bit(1'b0, 1'b1);
      send_bit(1'b0, 1'b1);
      check("mid_busy",  busy_m,  32'h1);
      check("mid_valid", valid_m, 32'h0);
      check("mid_ferr",  ferr_m,  32'h0);
      send_frame(8'h81, 1'b1, 1'b0);
      check("81_ferr",  ferr_m,  32'h1);
      check("81_dout",  dout_m,  32'h81);
      check("81_valid", valid_m, 32'h1);
      send_bit(1'b0, 1'b0);

      // overrun
      out_ready = 1'b0;
      send_frame(8'h3C, 1'b0, 1'b0);
      send_frame(8'hC3, 1'b0, 1'b0);
      check("ovr_dout",  dout_m,  32'h3C);
      check("ovr_valid", valid_m, 32'h1);
      check("ovr_flag",  ovr_m,   32'h1);
      out_ready = 1'b1;
      send_bit(1'b0, 1'b0);
      check("ovr_valid_drop", valid_m, 32'h0);
      check("ovr_sticky",     ovr_m,   32'h1);

      // reset mid-frame
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b1);
      send_bit(1'b0, 1'b1);
      check("pre_rst_busy", busy_m, 32'h1);
      rst = 1'b1;
      #1;
      check("mrst_dout",  dout_m,  32'h0);
      check("mrst_valid", valid_m, 32'h0);
      check("mrst_busy",  busy_m,  32'h0);
      check("mrst_ovr",   ovr_m,   32'h0);
      check("mrst_ferr",  ferr_m,  32'h0);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      send_frame(8'h55, 1'b1, 1'b0);
      check("55_dout",  dout_m,  32'h55);
      check("55_valid", valid_m, 32'h1);
      check("55_ovr",   ovr_m,   32'h0);
      check("55_ferr",  ferr_m,  32'h0);
      check("55_perr",  perr_m,  32'h0);
      send_bit(1'b0, 1'b0);

`ifdef SIPO_PARITY_EN
      send_frame(8'hA5, 1'b1, 1'b1);
      check("par_dout",  dout_m,  32'hA5);
      check("par_valid", valid_m, 32'h1);
      check("par_err",   perr_m,  32'h1);
`else
      send_frame(8'hA5, 1'b1, 1'b0);
      check("nopar_dout", dout_m, 32'hA5);
      check("nopar_perr", perr_m, 32'h0);
`endif
      send_bit(1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
